ex_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle integer multiply/divide unit for the EX stage (RV32M MUL/MULH*/DIV*/REM*).

---
 rtl/ex_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply/divide unit with req/gnt/rvalid handshake
// Multiply through a counted latency stage; divide by restoring 1-bit-per-cycle iteration.
module ex_muldiv_unit #(
   parameter int DWIDTH  = 32,
   parameter int MUL_LAT = 2,
   parameter int TAG_W   = 5
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [2:0]        op_i,
   input  logic [DWIDTH-1:0] operand_a_i,
   input  logic [DWIDTH-1:0] operand_b_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              flush_i,
   output logic              rvalid_o,
   output logic [DWIDTH-1:0] result_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              busy_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int CNT_MAX = (DWIDTH > MUL_LAT) ? DWIDTH : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [DWIDTH-1:0] MIN_VAL = {1'b1, {(DWIDTH-1){1'b0}}};

   logic [1:0]        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        op_q;
   logic [DWIDTH-1:0] a_q;
   logic [DWIDTH-1:0] b_q;
   logic [DWIDTH-1:0] quo_q;
   logic [DWIDTH-1:0] rem_q;
   logic [TAG_W-1:0]  tag_q;
   logic              neg_q_q;
   logic              neg_r_q;

   logic              accept;
   logic              div_signed;
   logic              a_neg;
   logic              b_neg;
   logic [DWIDTH-1:0] a_mag;
   logic [DWIDTH-1:0] b_mag;
   logic              b_zero;
   logic              div_ovf;

   logic                  a_sgn_mul;
   logic                  b_sgn_mul;
   logic [2*DWIDTH-1:0]   a_ext;
   logic [2*DWIDTH-1:0]   b_ext;
   logic [2*DWIDTH-1:0]   product;
   logic [DWIDTH-1:0]     mul_res;

   logic [DWIDTH:0]   div_shift;
   logic              div_ge;
   logic [DWIDTH-1:0] div_sub;
   logic [DWIDTH-1:0] rem_next;
   logic [DWIDTH-1:0] quo_fix;
   logic [DWIDTH-1:0] rem_fix;
   logic [DWIDTH-1:0] div_res;

   assign gnt_o    = ((state_q == S_IDLE) || (state_q == S_DONE)) && !flush_i;
   assign rvalid_o = (state_q == S_DONE) && !flush_i;
   assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
   assign accept   = req_i && gnt_o;

   // DIV and REM have funct3[0] clear; only those use sign-magnitude handling.
   assign div_signed = !op_i[0];
   assign a_neg      = div_signed && operand_a_i[DWIDTH-1];
   assign b_neg      = div_signed && operand_b_i[DWIDTH-1];
   assign a_mag      = a_neg ? -operand_a_i : operand_a_i;
   assign b_mag      = b_neg ? -operand_b_i : operand_b_i;
   assign b_zero     = (operand_b_i == '0);
   assign div_ovf    = div_signed && (operand_a_i == MIN_VAL) && (operand_b_i == '1);

   assign a_sgn_mul = (op_q == 3'b001) || (op_q == 3'b010);
   assign b_sgn_mul = (op_q == 3'b001);
   assign a_ext     = {{DWIDTH{a_sgn_mul & a_q[DWIDTH-1]}}, a_q};
   assign b_ext     = {{DWIDTH{b_sgn_mul & b_q[DWIDTH-1]}}, b_q};
   assign product   = a_ext * b_ext;
   assign mul_res   = (op_q[1:0] == 2'b00) ? product[DWIDTH-1:0] : product[2*DWIDTH-1:DWIDTH];

   // The partial remainder stays below the divisor, so DWIDTH bits hold it after each step.
   assign div_shift = {rem_q, quo_q[DWIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_sub   = div_shift[DWIDTH-1:0] - b_q;
   assign rem_next  = div_ge ? div_sub : div_shift[DWIDTH-1:0];
   assign quo_fix   = neg_q_q ? -quo_q : quo_q;
   assign rem_fix   = neg_r_q ? -rem_q : rem_q;
   assign div_res   = op_q[1] ? rem_fix : quo_fix;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         tag_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         result_o <= '0;
         tag_o    <= '0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q  <= op_i;
                  tag_q <= tag_i;
                  if (!op_i[2]) begin
                     state_q <= S_MUL;
                     cnt_q   <= CNT_W'(MUL_LAT - 1);
                     a_q     <= operand_a_i;
                     b_q     <= operand_b_i;
                  end else if (b_zero || div_ovf) begin
                     // Special cases skip iteration: preload the final quotient/remainder.
                     state_q <= S_DIV;
                     cnt_q   <= '0;
                     b_q     <= operand_b_i;
                     quo_q   <= b_zero ? '1 : MIN_VAL;
                     rem_q   <= b_zero ? operand_a_i : '0;
                     neg_q_q <= 1'b0;
                     neg_r_q <= 1'b0;
                  end else begin
                     state_q <= S_DIV;
                     cnt_q   <= CNT_W'(DWIDTH);
                     b_q     <= b_mag;
                     quo_q   <= a_mag;
                     rem_q   <= '0;
                     neg_q_q <= a_neg ^ b_neg;
                     neg_r_q <= a_neg;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_MUL: begin
               if (cnt_q == '0) begin
                  state_q  <= S_DONE;
                  result_o <= mul_res;
                  tag_o    <= tag_q;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DIV: begin
               if (cnt_q == '0) begin
                  state_q  <= S_DONE;
                  result_o <= div_res;
                  tag_o    <= tag_q;
               end else begin
                  rem_q <= rem_next;
                  quo_q <= {quo_q[DWIDTH-2:0], div_ge};
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit at 32/2 and 16/1
// Directed table, randomized ops against an arithmetic model, and flush/reset/back-to-back sequences.
module tb_ex_muldiv_unit;

   logic clk;
   logic rst_n;

   logic [1:0]  req_v;
   logic [1:0]  flush_v;
   logic [2:0]  op_v  [2];
   logic [31:0] a_v   [2];
   logic [31:0] b_v   [2];
   logic [4:0]  tag_v [2];

   logic [1:0]  gnt_v;
   logic [1:0]  rvalid_v;
   logic [1:0]  busy_v;
   logic [31:0] res32;
   logic [15:0] res16;
   logic [4:0]  tago32;
   logic [4:0]  tago16;

   int checks;
   int errors;

   ex_muldiv_unit #(.DWIDTH(32), .MUL_LAT(2), .TAG_W(5)) dut32 (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req_v[0]), .gnt_o(gnt_v[0]),
      .op_i(op_v[0]), .operand_a_i(a_v[0]), .operand_b_i(b_v[0]), .tag_i(tag_v[0]),
      .flush_i(flush_v[0]), .rvalid_o(rvalid_v[0]), .result_o(res32), .tag_o(tago32),
      .busy_o(busy_v[0])
   );

   ex_muldiv_unit #(.DWIDTH(16), .MUL_LAT(1), .TAG_W(5)) dut16 (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req_v[1]), .gnt_o(gnt_v[1]),
      .op_i(op_v[1]), .operand_a_i(a_v[1][15:0]), .operand_b_i(b_v[1][15:0]), .tag_i(tag_v[1]),
      .flush_i(flush_v[1]), .rvalid_o(rvalid_v[1]), .result_o(res16), .tag_o(tago16),
      .busy_o(busy_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a32;
      logic [31:0] b32;
      logic [31:0] e32;
      logic [15:0] a16;
      logic [15:0] b16;
      logic [15:0] e16;
      logic [4:0]  tag;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [31:0] res_of(int d);
      return (d == 0) ? res32 : {16'h0, res16};
   endfunction

   function automatic logic [31:0] tag_of(int d);
      return (d == 0) ? {27'h0, tago32} : {27'h0, tago16};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic longint sext(logic [31:0] v, int w);
      longint u;
      u = longint'(v) & ((longint'(1) << w) - 1);
      return ((u >> (w - 1)) & 1) != 0 ? u - (longint'(1) << w) : u;
   endfunction

   // Arithmetic reference: RV32M semantics on mathematical integers, truncated to w bits.
   function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
      longint mask, sa, sb, ua, ub, r;
      logic [63:0] up;
      mask = (longint'(1) << w) - 1;
      ua = longint'(a) & mask;
      ub = longint'(b) & mask;
      sa = sext(a, w);
      sb = sext(b, w);
      case (op)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * ub) >>> w;
         3'd3: begin up = 64'(ua) * 64'(ub); r = longint'(up >> w); end
         3'd4: r = (ub == 0) ? -1 : ((sa == -(longint'(1) << (w-1)) && sb == -1) ? sa : sa / sb);
         3'd5: r = (ub == 0) ? -1 : ua / ub;
         3'd6: r = (ub == 0) ? sa : ((sa == -(longint'(1) << (w-1)) && sb == -1) ? 0 : sa % sb);
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r & mask);
   endfunction

   function automatic int exp_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w, int ml);
      bit sgn;
      if (op < 3'd4) return ml;
      sgn = (op == 3'd4) || (op == 3'd6);
      if (sext(b, w) == 0) return 1;
      if (sgn && sext(a, w) == -(longint'(1) << (w-1)) && sext(b, w) == -1) return 1;
      return w + 1;
   endfunction

   task automatic run_op(int d, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] tag, logic [31:0] exp, string name);
      int w;
      int lat;
      int n;
      bit busy_ok;
      w = (d == 0) ? 32 : 16;
      lat = exp_lat(op, a, b, w, (d == 0) ? 2 : 1);
      @(negedge clk);
      op_v[d] = op; a_v[d] = a; b_v[d] = b; tag_v[d] = tag; req_v[d] = 1'b1;
      #1;
      check({name, " gnt"}, 32'(gnt_v[d]), 32'd1);
      @(posedge clk);
      #1;
      req_v[d] = 1'b0;
      a_v[d] = $urandom; b_v[d] = $urandom; tag_v[d] = 5'($urandom);
      n = 0;
      busy_ok = 1'b1;
      while (n < 100 && !rvalid_v[d]) begin
         if (!busy_v[d]) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      check({name, " latency"}, 32'(n), 32'(lat));
      check({name, " busy"}, 32'(busy_ok), 32'd1);
      check({name, " result"}, res_of(d), exp);
      check({name, " tag"}, tag_of(d), 32'(tag));
      @(posedge clk);
      #1;
      check({name, " rvalid width"}, 32'(rvalid_v[d]), 32'd0);
   endtask

   function automatic logic [31:0] pick(int w);
      logic [31:0] m;
      m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return m;
         2: return (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
         3: return 32'($urandom_range(1, 20));
         default: return $urandom & m;
      endcase
   endfunction

   initial begin
      int n;
      bit seen;
      logic [31:0] held;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [4:0]  rt;

      checks = 0;
      errors = 0;
      vecs[0]  = '{3'd0, 32'h7,        32'hFFFFFFF9, 32'hFFFFFFCF, 16'h7,    16'hFFF9, 16'hFFCF, 5'd3};
      vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 16'h8000, 16'h8000, 16'h4000, 5'd1};
      vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd2};
      vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'd4};
      vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 16'hFFF9, 16'h2,    16'hFFFD, 5'd5};
      vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 16'hFFF9, 16'h2,    16'hFFFF, 5'd6};
      vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       16'd100,  16'd7,    16'd14,   5'd7};
      vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        16'd100,  16'd7,    16'd2,    5'd8};
      vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 16'd5,    16'd0,    16'hFFFF, 5'd9};
      vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        16'd5,    16'd0,    16'd5,    5'd10};
      vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 16'h8000, 16'hFFFF, 16'h8000, 5'd11};
      vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        16'h8000, 16'hFFFF, 16'h0,    5'd12};

      rst_n = 1'b0;
      req_v = '0;
      flush_v = '0;
      for (int d = 0; d < 2; d++) begin
         op_v[d] = '0; a_v[d] = '0; b_v[d] = '0; tag_v[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset gnt", 32'(gnt_v[d]), 32'd1);
         check("reset rvalid", 32'(rvalid_v[d]), 32'd0);
         check("reset busy", 32'(busy_v[d]), 32'd0);
         check("reset result", res_of(d), 32'd0);
         check("reset tag", tag_of(d), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(0, vecs[i].op, vecs[i].a32, vecs[i].b32, vecs[i].tag, vecs[i].e32, $sformatf("vec32_%0d", i));
         run_op(1, vecs[i].op, {16'h0, vecs[i].a16}, {16'h0, vecs[i].b16}, vecs[i].tag,
                {16'h0, vecs[i].e16}, $sformatf("vec16_%0d", i));
      end

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick((d == 0) ? 32 : 16);
            rb = pick((d == 0) ? 32 : 16);
            rt = 5'($urandom);
            run_op(d, rop, ra, rb, rt, model(rop, ra, rb, (d == 0) ? 32 : 16),
                   $sformatf("rand%0d_%0d op%0d", d, i, rop));
         end
      end

      // Flush during the tenth DIV cycle: no result, output held, grant back next cycle.
      for (int d = 0; d < 2; d++) begin
         held = res_of(d);
         @(negedge clk);
         op_v[d] = 3'd4; a_v[d] = 32'hFFFFFFF9; b_v[d] = 32'h2; tag_v[d] = 5'd21; req_v[d] = 1'b1;
         @(posedge clk);
         #1;
         req_v[d] = 1'b0;
         repeat (9) @(posedge clk);
         #1;
         flush_v[d] = 1'b1;
         #1;
         check("flush gnt low", 32'(gnt_v[d]), 32'd0);
         @(posedge clk);
         #1;
         flush_v[d] = 1'b0;
         #1;
         check("flush gnt next", 32'(gnt_v[d]), 32'd1);
         check("flush busy", 32'(busy_v[d]), 32'd0);
         seen = 1'b0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (rvalid_v[d]) seen = 1'b1;
         end
         check("flush no rvalid", 32'(seen), 32'd0);
         check("flush result held", res_of(d), held);
      end

      // Request together with flush is refused.
      @(negedge clk);
      op_v[0] = 3'd5; a_v[0] = 32'd9; b_v[0] = 32'd3; req_v[0] = 1'b1; flush_v[0] = 1'b1;
      #1;
      check("req+flush gnt", 32'(gnt_v[0]), 32'd0);
      @(posedge clk);
      #1;
      req_v[0] = 1'b0; flush_v[0] = 1'b0;
      check("req+flush busy", 32'(busy_v[0]), 32'd0);

      // Flush in the DONE cycle suppresses rvalid.
      @(negedge clk);
      op_v[0] = 3'd5; a_v[0] = 32'd5; b_v[0] = 32'd0; tag_v[0] = 5'd13; req_v[0] = 1'b1;
      @(posedge clk);
      #1;
      req_v[0] = 1'b0;
      @(posedge clk);
      #1;
      flush_v[0] = 1'b1;
      #1;
      check("done flush rvalid", 32'(rvalid_v[0]), 32'd0);
      @(negedge clk);
      flush_v[0] = 1'b0;
      @(posedge clk);
      #1;
      check("done flush idle rvalid", 32'(rvalid_v[0]), 32'd0);

      // Back-to-back: a request held in the DONE cycle is accepted.
      @(negedge clk);
      op_v[0] = 3'd5; a_v[0] = 32'd100; b_v[0] = 32'd7; tag_v[0] = 5'd4; req_v[0] = 1'b1;
      @(posedge clk);
      #1;
      req_v[0] = 1'b0;
      n = 0;
      while (n < 100 && !rvalid_v[0]) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b first latency", 32'(n), 32'd33);
      check("b2b first result", res32, 32'd14);
      op_v[0] = 3'd0; a_v[0] = 32'd7; b_v[0] = 32'hFFFFFFF9; tag_v[0] = 5'd9; req_v[0] = 1'b1;
      #1;
      check("b2b gnt in done", 32'(gnt_v[0]), 32'd1);
      @(posedge clk);
      #1;
      req_v[0] = 1'b0;
      n = 0;
      while (n < 100 && !rvalid_v[0]) begin
         if (n == 1) check("b2b result held", res32, 32'd14);
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b second latency", 32'(n), 32'd2);
      check("b2b second result", res32, 32'hFFFFFFCF);
      check("b2b second tag", {27'h0, tago32}, 32'd9);

      // Asynchronous reset mid-DIV.
      @(negedge clk);
      op_v[0] = 3'd4; a_v[0] = 32'd1000; b_v[0] = 32'd3; tag_v[0] = 5'd17; req_v[0] = 1'b1;
      @(posedge clk);
      #1;
      req_v[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst busy", 32'(busy_v[0]), 32'd0);
      check("arst gnt", 32'(gnt_v[0]), 32'd1);
      check("arst rvalid", 32'(rvalid_v[0]), 32'd0);
      check("arst result", res32, 32'd0);
      check("arst tag", {27'h0, tago32}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (rvalid_v[0]) seen = 1'b1;
      end
      check("arst no rvalid", 32'(seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
